wta_fire_ctrl: RTL and testbench

- Consumes the registered 8-bit winner index from the 8-input winner-take-all comparator.
- Resolves the index to one neuron ID, then issues a one-cycle potential reset to the winning neuron.
- Holds lateral inhibition on all 8 neurons for a refractory window.
- Hands the winner ID to the STDP learning unit over a valid/ready handshake.

---
 rtl/wta_fire_ctrl_if.sv | 37 +++
 rtl/wta_fire_ctrl.sv | 144 ++++++++++++++
 tb/tb_wta_fire_ctrl.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/wta_fire_ctrl_if.sv
// wta_fire_ctrl_if: comparator, neuron and learning-unit bundle
// for the winner-take-all fire controller.
interface wta_fire_ctrl_if;
  logic [7:0] i_index;
  logic       i_enable;
  logic       i_learn_ready;
  logic [7:0] o_neuron_rst;
  logic [7:0] o_inhibit;
  logic       o_learn_valid;
  logic [2:0] o_learn_id;
  logic       o_busy;
  logic       o_multi;

  modport master (
    output i_index,
    output i_enable,
    output i_learn_ready,
    input  o_neuron_rst,
    input  o_inhibit,
    input  o_learn_valid,
    input  o_learn_id,
    input  o_busy,
    input  o_multi
  );

  modport slave (
    input  i_index,
    input  i_enable,
    input  i_learn_ready,
    output o_neuron_rst,
    output o_inhibit,
    output o_learn_valid,
    output o_learn_id,
    output o_busy,
    output o_multi
  );
endinterface

// File: rtl/wta_fire_ctrl.sv
// wta_fire_ctrl: fire, inhibit and learn-handoff sequencer.
// Optional per-neuron win counters when WINNER_COUNT_EN is defined.
module wta_fire_ctrl #(
  parameter int unsigned p_refract   = 16,
  parameter int unsigned p_cnt_width = 8
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
`ifdef WINNER_COUNT_EN
  input  logic [2:0]             i_cnt_sel,
  input  logic                   i_cnt_clr,
  output logic [p_cnt_width-1:0] o_win_cnt,
`endif
  wta_fire_ctrl_if.slave         bus
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FIRE,
    ST_LEARN,
    ST_REFRACT
  } state_t;

  localparam logic [7:0] RefLoad = 8'(p_refract - 1);

  state_t     st;
  logic [7:0] cnt;
  logic [2:0] id;
  logic [7:0] neuron_rst;
  logic [7:0] inhibit;
  logic       learn_valid;
  logic [2:0] learn_id;
  logic       multi;

  logic       cnt_zero;
  logic       leaving;
  logic       take;
  logic       many;
  logic [2:0] lsb_id;

  function automatic logic [2:0] lsb_pos(input logic [7:0] v);
    logic [2:0] p;
    p = '0;
    for (int k = 7; k >= 0; k--) begin
      if (v[k]) p = 3'(k);
    end
    return p;
  endfunction

  // The last cycle of a busy window may already accept a new winner.
  assign cnt_zero = (cnt == 8'd0);
  assign leaving  = ((st == ST_LEARN) && bus.i_learn_ready && cnt_zero)
                 || ((st == ST_REFRACT) && cnt_zero);
  assign take     = bus.i_enable && (|bus.i_index)
                 && ((st == ST_IDLE) || leaving);
  assign many     = |(bus.i_index & (bus.i_index - 8'd1));
  assign lsb_id   = lsb_pos(bus.i_index);

  assign bus.o_neuron_rst  = neuron_rst;
  assign bus.o_inhibit     = inhibit;
  assign bus.o_learn_valid = learn_valid;
  assign bus.o_learn_id    = learn_id;
  assign bus.o_multi       = multi;
  assign bus.o_busy        = (st != ST_IDLE);

  // Sequencer with registered outputs and refractory countdown.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      st          <= ST_IDLE;
      cnt         <= '0;
      id          <= '0;
      neuron_rst  <= '0;
      inhibit     <= '0;
      learn_valid <= 1'b0;
      learn_id    <= '0;
      multi       <= 1'b0;
    end else begin
      neuron_rst <= '0;
      multi      <= 1'b0;
      if ((st != ST_IDLE) && !cnt_zero) cnt <= cnt - 8'd1;

      unique case (st)
        ST_IDLE: begin
          inhibit <= '0;
        end
        ST_FIRE: begin
          st          <= ST_LEARN;
          learn_valid <= 1'b1;
          learn_id    <= id;
        end
        ST_LEARN: begin
          if (bus.i_learn_ready) begin
            learn_valid <= 1'b0;
            learn_id    <= '0;
            if (cnt_zero) begin
              st      <= ST_IDLE;
              inhibit <= '0;
            end else begin
              st <= ST_REFRACT;
            end
          end
        end
        ST_REFRACT: begin
          if (cnt_zero) begin
            st      <= ST_IDLE;
            inhibit <= '0;
          end
        end
        default: st <= ST_IDLE;
      endcase

      if (take) begin
        st         <= ST_FIRE;
        id         <= lsb_id;
        cnt        <= RefLoad;
        neuron_rst <= 8'd1 << lsb_id;
        inhibit    <= 8'hFF;
        multi      <= many;
      end
    end
  end

`ifdef WINNER_COUNT_EN
  localparam logic [p_cnt_width-1:0] CntOne =
    {{(p_cnt_width-1){1'b0}}, 1'b1};

  logic [p_cnt_width-1:0] win_cnt [8];

  // Saturating win counters; clear beats a same-cycle increment.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n || i_cnt_clr) begin
      for (int k = 0; k < 8; k++) win_cnt[k] <= '0;
    end else if (take && !(&win_cnt[lsb_id])) begin
      win_cnt[lsb_id] <= win_cnt[lsb_id] + CntOne;
    end
  end

  assign o_win_cnt = win_cnt[i_cnt_sel];
`else
  logic [31:0] unused_cnt_width;
  assign unused_cnt_width = 32'(p_cnt_width);
`endif

endmodule

// File: tb/tb_wta_fire_ctrl.sv
// tb_wta_fire_ctrl: directed bench with an elapsed-time
// reference model for the fire controller.
module tb_wta_fire_ctrl;
  localparam int R = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  wta_fire_ctrl_if bus();

  logic [2:0] cnt_sel = 3'd0;
  logic       cnt_clr = 1'b0;
`ifdef WINNER_COUNT_EN
  logic [7:0] win_cnt;
`endif

  wta_fire_ctrl #(.p_refract(R), .p_cnt_width(8)) dut (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
`ifdef WINNER_COUNT_EN
    .i_cnt_sel (cnt_sel),
    .i_cnt_clr (cnt_clr),
    .o_win_cnt (win_cnt),
`endif
    .bus       (bus)
  );

  int errs = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s: got %0d want %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a win occupies the block from its capture edge N until edge
  // max(accept edge, N+R); a new win can be taken on that last edge.
  bit         m_act, m_acc, m_multi, m_end, m_free;
  int         m_k, m_id;
  int         m_cnt [8];
  logic [7:0] m_mask;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_act = 0; m_acc = 0; m_multi = 0; m_k = 0; m_id = 0;
      for (int i = 0; i < 8; i++) m_cnt[i] = 0;
    end else begin
      m_end = 0;
      m_multi = 0;
      if (m_act) begin
        if (!m_acc && m_k >= 1 && bus.i_learn_ready) m_acc = 1;
        m_k++;
        m_end = m_acc && (m_k >= R);
      end
      m_free = !m_act || m_end;
      if (m_free && bus.i_enable && bus.i_index != 8'd0) begin
        m_act = 1; m_acc = 0; m_k = 0;
        m_mask = bus.i_index & (~bus.i_index + 8'd1);
        m_id = $clog2(m_mask);
        m_multi = $countones(bus.i_index) > 1;
        if (m_cnt[m_id] < 255) m_cnt[m_id]++;
      end else if (m_free) begin
        m_act = 0;
      end
      if (cnt_clr) for (int i = 0; i < 8; i++) m_cnt[i] = 0;
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      bit v;
      v = m_act && m_k >= 1 && !m_acc;
      chk("m_neuron_rst", bus.o_neuron_rst,
          (m_act && m_k == 0) ? (1 << m_id) : 0);
      chk("m_inhibit", bus.o_inhibit, m_act ? 8'hFF : 0);
      chk("m_learn_valid", bus.o_learn_valid, v);
      chk("m_learn_id", bus.o_learn_id, v ? m_id : 0);
      chk("m_busy", bus.o_busy, m_act);
      chk("m_multi", bus.o_multi, m_multi);
`ifdef WINNER_COUNT_EN
      chk("m_win_cnt", win_cnt, m_cnt[cnt_sel]);
`endif
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic win(input logic [7:0] v);
    bus.i_index = v; bus.i_enable = 1'b1;
    tick();
    bus.i_index = 8'd0; bus.i_enable = 1'b0;
    repeat (R + 1) tick();
  endtask

  int inh_n, rst_pulses, val_n;

  initial begin
    bus.i_index = 8'd0;
    bus.i_enable = 1'b0;
    bus.i_learn_ready = 1'b1;
    tick(); tick();
    chk_en = 1'b1;
    chk("rst_inhibit", bus.o_inhibit, 0);
    chk("rst_busy", bus.o_busy, 0);
    chk("rst_valid", bus.o_learn_valid, 0);
    rst_n = 1'b1;
    tick();

    // Single win on neuron 5
    bus.i_index = 8'h20; bus.i_enable = 1'b1;
    tick();
    bus.i_index = 8'h00; bus.i_enable = 1'b0;
    chk("t1_rst", bus.o_neuron_rst, 8'h20);
    inh_n = 1; rst_pulses = 1; val_n = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (bus.o_inhibit == 8'hFF) inh_n++;
      if (bus.o_neuron_rst != 8'd0) rst_pulses++;
      if (bus.o_learn_valid) begin
        val_n++;
        chk("t1_id", bus.o_learn_id, 5);
      end
    end
    chk("t1_inh_len", inh_n, 16);
    chk("t1_rst_len", rst_pulses, 1);
    chk("t1_valid_len", val_n, 1);
    chk("t1_busy", bus.o_busy, 0);

    // Tie-break 8'h48 -> neuron 3
    bus.i_index = 8'h48; bus.i_enable = 1'b1;
    tick();
    bus.i_index = 8'h00; bus.i_enable = 1'b0;
    chk("t2_rst", bus.o_neuron_rst, 8'h08);
    chk("t2_multi", bus.o_multi, 1);
    tick();
    chk("t2_multi_off", bus.o_multi, 0);
    chk("t2_id", bus.o_learn_id, 3);
    repeat (20) tick();

    // Handshake stall on neuron 2
    bus.i_learn_ready = 1'b0;
    bus.i_index = 8'h04; bus.i_enable = 1'b1;
    tick();
    bus.i_index = 8'h00; bus.i_enable = 1'b0;
    for (int i = 0; i < 30; i++) begin
      tick();
      chk("t3_valid", bus.o_learn_valid, 1);
      chk("t3_id", bus.o_learn_id, 2);
      chk("t3_inh", bus.o_inhibit, 8'hFF);
    end
    bus.i_learn_ready = 1'b1;
    tick();
    chk("t3_idle", bus.o_busy, 0);
    chk("t3_inh_off", bus.o_inhibit, 0);
    chk("t3_valid_off", bus.o_learn_valid, 0);
    repeat (3) tick();

    // Second winner while in REFRACT is dropped
    bus.i_index = 8'h80; bus.i_enable = 1'b1;
    tick();
    bus.i_index = 8'h00; bus.i_enable = 1'b0;
    tick(); tick();
    bus.i_index = 8'h01; bus.i_enable = 1'b1;
    rst_pulses = 0;
    repeat (5) begin
      tick();
      if (bus.o_neuron_rst != 8'd0) rst_pulses++;
    end
    chk("t4_ignored", rst_pulses, 0);
    bus.i_index = 8'h00; bus.i_enable = 1'b0;
    repeat (15) tick();
    chk("t4_idle", bus.o_busy, 0);
    bus.i_index = 8'h01; bus.i_enable = 1'b1;
    tick();
    bus.i_index = 8'h00; bus.i_enable = 1'b0;
    chk("t4_rst", bus.o_neuron_rst, 8'h01);
    repeat (R + 2) tick();

    // Reset during LEARN
    bus.i_learn_ready = 1'b0;
    bus.i_index = 8'h02; bus.i_enable = 1'b1;
    tick();
    bus.i_index = 8'h00; bus.i_enable = 1'b0;
    tick();
    chk("t5_valid", bus.o_learn_valid, 1);
    rst_n = 1'b0;
    tick();
    chk("t5_inh", bus.o_inhibit, 0);
    chk("t5_valid0", bus.o_learn_valid, 0);
    chk("t5_id0", bus.o_learn_id, 0);
    chk("t5_busy", bus.o_busy, 0);
    rst_n = 1'b1;
    bus.i_learn_ready = 1'b1;
    bus.i_enable = 1'b1;
    repeat (5) begin
      tick();
      chk("t5_quiet", bus.o_busy, 0);
    end
    bus.i_enable = 1'b0;
    tick();

`ifdef WINNER_COUNT_EN
    win(8'h80); win(8'h80); win(8'h80); win(8'h01);
    cnt_sel = 3'd7; #1;
    chk("t6_cnt7", win_cnt, 3);
    cnt_sel = 3'd0; #1;
    chk("t6_cnt0", win_cnt, 1);
    cnt_sel = 3'd7;
    cnt_clr = 1'b1;
    bus.i_index = 8'h80; bus.i_enable = 1'b1;
    tick();
    cnt_clr = 1'b0;
    bus.i_index = 8'h00; bus.i_enable = 1'b0;
    chk("t6_clr", win_cnt, 0);
    chk("t6_clr_fire", bus.o_neuron_rst, 8'h80);
    repeat (R + 1) tick();
    repeat (256) win(8'h80);
    chk("t6_sat", win_cnt, 255);
`endif

    repeat (3) tick();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
